serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_fa_bit.sv | 18 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared FSM state type and default operand width for the bit-serial adder.
package serial_adder_pkg;
   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_t;

   // Counter must hold WIDTH itself so it never wraps mid-operation.
   function automatic int sa_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder from two half-adder stages and an OR; purely combinational, no flow control.
module fa_bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   assign w_s1 = x ^ y;
   assign w_c1 = x & y;
   assign s    = w_s1 ^ ci;
   assign w_c2 = w_s1 & ci;
   assign co   = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial a+b, LSB first; done pulses WIDTH+1 cycles after accept, start ignored while busy.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CNT_W = sa_cnt_w(WIDTH);

   sa_state_t        r_state;
   sa_state_t        w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_res_nxt;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   fa_bit u_fa (
      .x  (r_a[0]),
      .y  (r_b[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept  = start && (r_state != ST_RUN);
   // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
   assign w_res_nxt = (r_res >> 1) | ({{(WIDTH-1){1'b0}}, w_s} << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == ST_RUN);
      done = (r_state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_res   <= w_res_nxt;
         r_carry <= w_co;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_sum  <= w_res_nxt;
            r_cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
            // On the last bit the carry flop holds the carry into the MSB.
            r_ovf  <= r_carry ^ w_co;
`endif
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8; checks ovf too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
      check({tag, ".sum"}, 32'(sum), 32'(es));
      check({tag, ".cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
   endtask

   // Entered at a negedge; inj_k > 0 re-asserts start with junk operands at that RUN cycle.
   task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] es, input logic ec, input logic eo, input int inj_k);
      int nbusy = 0;
      int ndone = 0;
      int kdone = -1;
      a = ia;
      b = ib;
      start = 1'b1;
      for (int k = 1; k <= W + 2; k++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            kdone = k;
            check_res(tag, es, ec, eo);
         end
         if (k == inj_k) begin
            start = 1'b1;
            a = ~ia;
            b = 8'h5A;
         end else begin
            start = 1'b0;
         end
      end
      check({tag, ".busy_cycles"}, 32'(nbusy), 32'(W));
      check({tag, ".done_cycle"}, 32'(kdone), 32'(W + 1));
      check({tag, ".done_count"}, 32'(ndone), 32'd1);
      check({tag, ".sum_hold"}, 32'(sum), 32'(es));
   endtask

   logic [W-1:0] bb_a  [4] = '{8'h35, 8'hFF, 8'h80, 8'hC3};
   logic [W-1:0] bb_b  [4] = '{8'h4A, 8'h01, 8'h80, 8'h5A};
   logic [W-1:0] bb_s  [4] = '{8'h7F, 8'h00, 8'h00, 8'h1D};
   logic         bb_c  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
   logic         bb_o  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int idx;
      int last_t;
      int ndone;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.sum", 32'(sum), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      op("basic", 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 0);
      op("wrap", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
      op("sovf", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
      op("ign_start", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);

      // Back-to-back: start held high, next operands presented while DONE is showing.
      idx = 0;
      last_t = 0;
      a = bb_a[0];
      b = bb_b[0];
      start = 1'b1;
      for (int t = 1; t <= 4 * (W + 1) + 4 && idx < 4; t++) begin
         @(negedge clk);
         if (done) begin
            check_res($sformatf("b2b%0d", idx), bb_s[idx], bb_c[idx], bb_o[idx]);
            check($sformatf("b2b%0d.period", idx), 32'(t - last_t), 32'(W + 1));
            last_t = t;
            idx++;
            if (idx < 4) begin
               a = bb_a[idx];
               b = bb_b[idx];
            end else begin
               start = 1'b0;
            end
         end
      end
      check("b2b.results", 32'(idx), 32'd4);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Reset at RUN cycle 4 aborts the operation.
      a = 8'hA5;
      b = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid.busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid.busy", 32'(busy), 32'd0);
      check("mid.done", 32'(done), 32'd0);
      check("mid.sum", 32'(sum), 32'd0);
      check("mid.cout", 32'(cout), 32'd0);
      ndone = 0;
      for (int k = 0; k < 2 * W; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("mid.no_done", 32'(ndone), 32'd0);
      op("after_rst", 8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
